// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
// Groups the byte-write side and the transmitter side of the TX FIFO.
//   wr_en / wr_data                 : bus-side write strobe and byte
//   full / empty / level / overflow : FIFO status
//   tx_en / tx_data                 : launch pulse and byte to the transmitter
//   tx_busy / tx_done               : transmitter status back to the FIFO
//   active                          : a frame is launched and not yet done
// master = bus side plus transmitter; slave = uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          tx_en;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          tx_done;
    logic          active;

    modport master (
        output wr_en, wr_data, tx_busy, tx_done,
        input  full, empty, level, overflow, tx_en, tx_data, active
    );

    modport slave (
        input  wr_en, wr_data, tx_busy, tx_done,
        output full, empty, level, overflow, tx_en, tx_data, active
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Circular byte FIFO in front of the UART transmitter. Each stored byte is
// launched with a one-cycle tx_en pulse. The next byte waits for the
// transmitter's done pulse.
// Ports:
//   clk    : clock shared with the transmitter
//   arst_n : asynchronous active-low reset
//   clr    : synchronous clear of FIFO, overflow and FSM (highest priority)
//   enable : gates new launches only; writes are always accepted
//   bus    : uart_tx_fifo_if.slave (write side, status, transmitter side)
module uart_tx_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           clr,
    input  logic           enable,
    uart_tx_fifo_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_nxt;
    logic [AW:0]   rd_ptr_nxt;
    logic          full_r;
    logic          empty_r;
    logic [AW:0]   level_r;
    logic          overflow_r;
    logic          tx_en_r;
    logic [7:0]    tx_data_r;
    logic          active_r;
    logic          push;
    logic          pop;

    // full/empty are the registered flags, so a write into an empty FIFO
    // cannot launch in the same cycle and a write while full is rejected
    // even when a pop happens in that cycle.
    always_comb begin
        push       = bus.wr_en && !full_r && !clr;
        pop        = (state == ST_IDLE) && enable && !empty_r && !bus.tx_busy && !clr;
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
        if (clr) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end
    end

    // Flags are registered from the next pointer values so they match the
    // pointers right after each edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            level_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            empty_r <= (wr_ptr_nxt == rd_ptr_nxt);
            full_r  <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                       (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
            level_r <= wr_ptr_nxt - rd_ptr_nxt;
            if (clr) begin
                overflow_r <= 1'b0;
            end else if (bus.wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Storage carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

    // Launch FSM. clr returns to idle but keeps tx_data. A frame already on
    // the line is protected by the !tx_busy guard on the next launch.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= ST_IDLE;
            tx_en_r   <= 1'b0;
            tx_data_r <= 8'h00;
            active_r  <= 1'b0;
        end else if (clr) begin
            state    <= ST_IDLE;
            tx_en_r  <= 1'b0;
            active_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data_r <= mem[rd_ptr[AW-1:0]];
                        tx_en_r   <= 1'b1;
                        active_r  <= 1'b1;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    tx_en_r <= 1'b0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.tx_done) begin
                        active_r <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    tx_en_r  <= 1'b0;
                    active_r <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
    assign bus.level    = level_r;
    assign bus.overflow = overflow_r;
    assign bus.tx_en    = tx_en_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.active   = active_r;

endmodule
